kbd_char_fifo: RTL and testbench

//  Downstream of the PS/2 keyboard decoder. Samples its 8-bit level ASCII output (held while the key is down, 0 on release).

---
 rtl/kbd_pkg.sv | 26 ++
 rtl/sync_fifo_fwft.sv | 70 +++++++
 rtl/kbd_char_fifo.sv | 158 +++++++++++++++
 tb/tb_kbd_char_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard character path.
// Holds the modifier key codes that the filter recognises, the qualifier
// state encoding, and a helper that classifies a code as a modifier.
package kbd_pkg;

   // Modifier codes emitted by the keyboard decoder; these never reach the CPU
   // when filtering is enabled.
   localparam logic [7:0] KBD_SHIFT = 8'h10;
   localparam logic [7:0] KBD_CTRL  = 8'h11;
   localparam logic [7:0] KBD_CAPS  = 8'h14;
   localparam logic [7:0] KBD_NUM   = 8'h90;

   // Keystroke qualifier states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HELD = 2'd2
   } qual_state_t;

   // True when the code is one of the modifier keys.
   function automatic logic is_modifier(input logic [7:0] code);
      return (code == KBD_SHIFT) || (code == KBD_CTRL) ||
             (code == KBD_CAPS)  || (code == KBD_NUM);
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO, shared by the keyboard and UART paths.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   wr_en, wr_data   push request and data; dropped when full unless popped the same edge
//   rd_en            pop the head entry; ignored while empty
//   rd_data          head entry, forced to 0 while empty
//   empty, full      occupancy flags
//   count            number of entries held (0..DEPTH)
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A push into a full FIFO still succeeds when the head leaves on the same edge.
   assign do_pop  = rd_en && !empty;
   assign do_push = wr_en && (!full || do_pop);

   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; count moves
   // by at most one per cycle and is unchanged on a simultaneous push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; stale contents are hidden by the pointers and the empty gate.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/kbd_char_fifo.sv
// Keystroke buffer behind the PS/2 keyboard decoder.
// Qualifies the level key_code into one push per new keystroke, optionally drops
// modifier codes, and buffers characters in a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   key_code          level ASCII from the decoder, 0 = no key
//   rd_en             pop head entry
//   rd_data           head entry (0 while empty)
//   empty, full       occupancy flags
//   count             entries held
//   overflow, clr_ovf sticky lost-character flag and its clear
module kbd_char_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int STABLE_CYC = 4,
   parameter int FILTER_MOD = 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    key_code,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count,
   output logic          overflow,
   input  logic          clr_ovf
);

   qual_state_t state, state_nxt;
   logic [7:0]  cand, cand_nxt;
   logic [7:0]  last_code, last_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic        push_q, push_nxt;
   logic [7:0]  push_data_q, push_data_nxt;
   logic        load_new;
   logic        qualify;
   logic        ovf_event;

   // Qualifier registers; push_q is the single-cycle push event into the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cand        <= '0;
         last_code   <= '0;
         cnt         <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
      end else begin
         state       <= state_nxt;
         cand        <= cand_nxt;
         last_code   <= last_nxt;
         cnt         <= cnt_nxt;
         push_q      <= push_nxt;
         push_data_q <= push_data_nxt;
      end
   end

   // Next-state logic. A code must hold for STABLE_CYC cycles before it is
   // qualified; a qualified code is pushed only if it differs from the last one
   // and is not a filtered modifier. Releasing a held key forgets last_code so
   // the same key pressed again is accepted.
   always_comb begin
      state_nxt     = state;
      cand_nxt      = cand;
      last_nxt      = last_code;
      cnt_nxt       = cnt;
      push_nxt      = 1'b0;
      push_data_nxt = push_data_q;
      load_new      = 1'b0;
      qualify       = 1'b0;

      case (state)
         IDLE: begin
            if (key_code != 8'h00) begin
               load_new = 1'b1;
            end
         end
         QUAL: begin
            if (key_code == cand) begin
               if ((cnt + 8'd1) == 8'(STABLE_CYC)) begin
                  qualify = 1'b1;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end else if (key_code == 8'h00) begin
               state_nxt = IDLE;
            end else begin
               load_new = 1'b1;
            end
         end
         HELD: begin
            if (key_code == last_code) begin
               state_nxt = HELD;
            end else if (key_code == 8'h00) begin
               state_nxt = IDLE;
               last_nxt  = 8'h00;
            end else begin
               load_new = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (load_new) begin
         state_nxt = QUAL;
         cand_nxt  = key_code;
         cnt_nxt   = 8'd1;
         if (STABLE_CYC == 1) begin
            qualify = 1'b1;
         end
      end

      if (qualify) begin
         state_nxt = HELD;
         cnt_nxt   = 8'(STABLE_CYC);
         last_nxt  = cand_nxt;
         if ((cand_nxt != last_code) && !((FILTER_MOD != 0) && is_modifier(cand_nxt))) begin
            push_nxt      = 1'b1;
            push_data_nxt = cand_nxt;
         end
      end
   end

   // A push is lost only when the FIFO is full and nothing leaves on the same edge.
   assign ovf_event = push_q && full && !rd_en;

   // Sticky overflow; a new loss outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (ovf_event) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push_q),
      .wr_data (push_data_q),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

endmodule

// File: tb/tb_kbd_char_fifo.sv
// Directed bench for kbd_char_fifo with a queue scoreboard of expected characters.
module tb_kbd_char_fifo;

   localparam int DEPTH      = 4;
   localparam int STABLE_CYC = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] key_code;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [2:0] count;
   logic       overflow;
   logic       clr_ovf;

   int         n_checks;
   int         n_fail;
   logic [7:0] exp_q[$];
   logic       exp_ovf;

   kbd_char_fifo #(
      .DEPTH      (DEPTH),
      .STABLE_CYC (STABLE_CYC),
      .FILTER_MOD (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_code (key_code),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive a code for a number of cycles and record whether it should be buffered.
   task automatic applyStimulus(input logic [7:0] code, input int hold, input bit buffered);
      key_code = code;
      if (buffered) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(code);
         else exp_ovf = 1'b1;
      end
      tick(hold);
   endtask

   task automatic releaseKey();
      key_code = 8'h00;
      tick(3);
   endtask

   // Compare the head against the scoreboard, then pop it.
   task automatic readOne(input string tag);
      logic [7:0] e;
      checkOutput({tag, "_empty"}, 32'(empty), 32'd0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      checkOutput(tag, 32'(rd_data), 32'(e));
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_ovf  = 1'b0;
      rst_n    = 1'b0;
      key_code = 8'h00;
      rd_en    = 1'b0;
      clr_ovf  = 1'b0;
      tick(2);

      // Reset values.
      checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: single keystroke, latency and no typematic repeats.
      $display("[TB] single keystroke");
      applyStimulus(8'h61, 4, 1'b1);
      checkOutput("t1_empty_4th", 32'(empty), 32'd1);
      tick(1);
      checkOutput("t1_empty_5th", 32'(empty), 32'd0);
      checkOutput("t1_head", 32'(rd_data), 32'h61);
      tick(5);
      releaseKey();
      checkOutput("t1_count", 32'(count), 32'd1);
      readOne("t1_read");
      checkOutput("t1_empty_after", 32'(empty), 32'd1);
      checkOutput("t1_rd_data_zero", 32'(rd_data), 32'd0);

      // 2: short glitch is not qualified.
      $display("[TB] glitch");
      applyStimulus(8'h61, 2, 1'b0);
      key_code = 8'h00;
      tick(6);
      checkOutput("t2_empty", 32'(empty), 32'd1);
      checkOutput("t2_count", 32'(count), 32'd0);

      // 3: second key while first held, then repress.
      $display("[TB] rollover");
      applyStimulus(8'h61, 8, 1'b1);
      applyStimulus(8'h62, 8, 1'b1);
      releaseKey();
      applyStimulus(8'h61, 8, 1'b1);
      releaseKey();
      checkOutput("t3_count", 32'(count), 32'd3);
      readOne("t3_read0");
      readOne("t3_read1");
      readOne("t3_read2");
      checkOutput("t3_empty", 32'(empty), 32'd1);

      // 4: modifier filtered.
      $display("[TB] modifier filter");
      applyStimulus(8'h10, 8, 1'b0);
      applyStimulus(8'h41, 8, 1'b1);
      releaseKey();
      checkOutput("t4_count", 32'(count), 32'd1);
      readOne("t4_read");

      // 5: overflow, push+pop when full, clear.
      $display("[TB] overflow");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'h31 + 8'(i), 8, 1'b1);
         releaseKey();
      end
      checkOutput("t5_full4", 32'(full), 32'd1);
      checkOutput("t5_ovf_before", 32'(overflow), 32'(exp_ovf));
      applyStimulus(8'h35, 8, 1'b1);
      releaseKey();
      checkOutput("t5_count", 32'(count), 32'd4);
      checkOutput("t5_ovf", 32'(overflow), 32'(exp_ovf));
      key_code = 8'h36;
      tick(4);
      checkOutput("t5_head_at_pop", 32'(rd_data), 32'(exp_q.pop_front()));
      exp_q.push_back(8'h36);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(4);
      releaseKey();
      checkOutput("t5_count_pushpop", 32'(count), 32'd4);
      checkOutput("t5_full_pushpop", 32'(full), 32'd1);
      checkOutput("t5_ovf_kept", 32'(overflow), 32'd1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      checkOutput("t5_ovf_clr", 32'(overflow), 32'd0);
      while (exp_q.size() > 0) readOne("t5_drain");
      checkOutput("t5_empty", 32'(empty), 32'd1);

      // 6: reset mid-operation with a push pending.
      $display("[TB] reset mid-operation");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(8'h41 + 8'(i), 8, 1'b1);
         releaseKey();
      end
      checkOutput("t6_count3", 32'(count), 32'd3);
      key_code = 8'h44;
      tick(4);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      checkOutput("t6_rst_empty", 32'(empty), 32'd1);
      checkOutput("t6_rst_count", 32'(count), 32'd0);
      checkOutput("t6_rst_rd_data", 32'(rd_data), 32'd0);
      key_code = 8'h00;
      tick(1);
      rst_n = 1'b1;
      tick(3);
      checkOutput("t6_post_empty", 32'(empty), 32'd1);
      checkOutput("t6_post_count", 32'(count), 32'd0);
      applyStimulus(8'h31, 8, 1'b1);
      releaseKey();
      checkOutput("t6_fresh_count", 32'(count), 32'd1);
      readOne("t6_fresh_read");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
